// File: rtl/envelope_sample_writer.sv
// Paced ADSR-style (attack/sustain/release) sample source for the Audio_Controller write port.
// A square-wave tone is scaled by a linear envelope and offered once per SAMPLE_DIV clocks.
module envelope_sample_writer #(
    parameter int SAMPLE_DIV   = 1042,
    parameter int ENV_W        = 16,
    parameter int ATTACK_STEP  = 64,
    parameter int RELEASE_STEP = 16,
    parameter int AMP_SHIFT    = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             gate,
    input  logic             tone,
    input  logic             audio_out_allowed,
    output logic             write_audio_out,
    output logic [31:0]      left_channel_audio_out,
    output logic [31:0]      right_channel_audio_out,
    output logic [ENV_W-1:0] env_level,
    output logic [1:0]       env_state,
    output logic [7:0]       overrun_count
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam logic [ENV_W-1:0] ENV_MAX  = '1;
    localparam logic [ENV_W:0]   ATK_INC  = (ENV_W + 1)'(ATTACK_STEP);
    localparam logic [ENV_W:0]   REL_DEC  = (ENV_W + 1)'(RELEASE_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ATTACK  = 2'd1,
        ST_SUSTAIN = 2'd2,
        ST_RELEASE = 2'd3
    } env_state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] level_q, level_d;
    logic [31:0]      sample_q, sample_d;
    logic             pending_q, pending_d;
    logic [7:0]       overrun_q, overrun_d;

    logic             tick;
    logic             write_now;
    logic [ENV_W:0]   up_sum;
    logic [ENV_W:0]   dn_diff;
    logic [ENV_W-1:0] up_level;
    logic [ENV_W-1:0] dn_level;
    logic [31:0]      mag;

    always_comb begin
        tick      = (cnt_q == CNT_LAST);
        write_now = pending_q & audio_out_allowed;

        // One guard bit: carry out means saturate, borrow out means floor at zero.
        up_sum   = {1'b0, level_q} + ATK_INC;
        dn_diff  = {1'b0, level_q} - REL_DEC;
        up_level = (up_sum > {1'b0, ENV_MAX}) ? ENV_MAX : up_sum[ENV_W-1:0];
        dn_level = dn_diff[ENV_W] ? '0 : dn_diff[ENV_W-1:0];

        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        state_d   = state_q;
        level_d   = level_q;
        sample_d  = sample_q;
        pending_d = pending_q;
        overrun_d = overrun_q;

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (gate) begin
                        state_d = ST_ATTACK;
                        level_d = up_level;
                    end else begin
                        level_d = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                        level_d = dn_level;
                    end else begin
                        level_d = up_level;
                        if (up_level == ENV_MAX) state_d = ST_SUSTAIN;
                    end
                end
                ST_SUSTAIN: begin
                    if (!gate) begin
                        state_d = ST_RELEASE;
                        level_d = dn_level;
                    end else begin
                        level_d = ENV_MAX;
                    end
                end
                ST_RELEASE: begin
                    if (gate) begin
                        state_d = ST_ATTACK;
                        level_d = up_level;
                    end else begin
                        level_d = dn_level;
                        if (dn_level == '0) state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    level_d = '0;
                end
            endcase
        end

        mag = 32'(level_d) << AMP_SHIFT;

        // A tick always reloads; a write in the same cycle took the old sample, so it is no overrun.
        if (tick) begin
            sample_d  = tone ? mag : (~mag + 32'd1);
            pending_d = 1'b1;
            if (pending_q && !audio_out_allowed && overrun_q != 8'hFF)
                overrun_d = overrun_q + 8'd1;
        end else if (write_now) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            state_q   <= ST_IDLE;
            level_q   <= '0;
            sample_q  <= '0;
            pending_q <= 1'b0;
            overrun_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            sample_q  <= sample_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign write_audio_out         = write_now;
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign env_level               = level_q;
    assign env_state               = state_q;
    assign overrun_count           = overrun_q;

endmodule

// File: tb/tb_envelope_sample_writer.sv
// Bench for envelope_sample_writer: per-tick envelope model plus a pending-sample scoreboard.
module tb_envelope_sample_writer;

    localparam int SAMPLE_DIV   = 4;
    localparam int ENV_W        = 4;
    localparam int ATTACK_STEP  = 4;
    localparam int RELEASE_STEP = 2;
    localparam int AMP_SHIFT    = 0;
    localparam int MAXL         = (1 << ENV_W) - 1;

    localparam int S_IDLE = 0, S_ATTACK = 1, S_SUSTAIN = 2, S_RELEASE = 3;

    logic             clk;
    logic             reset_n;
    logic             gate;
    logic             tone;
    logic             allowed;
    logic             write_audio_out;
    logic [31:0]      left_out;
    logic [31:0]      right_out;
    logic [ENV_W-1:0] env_level;
    logic [1:0]       env_state;
    logic [7:0]       overrun_count;

    int checks   = 0;
    int failures = 0;

    // Model state: the queue holds the sample waiting to be written (at most one).
    logic [31:0] exp_q[$];
    int          m_cnt;
    int          m_state;
    int          m_level;
    logic [31:0] m_sample;
    int          m_overrun;
    int          n_writes;
    int          n_ticks;

    envelope_sample_writer #(
        .SAMPLE_DIV  (SAMPLE_DIV),
        .ENV_W       (ENV_W),
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP),
        .AMP_SHIFT   (AMP_SHIFT)
    ) dut (
        .CLOCK_50               (clk),
        .reset_n                (reset_n),
        .gate                   (gate),
        .tone                   (tone),
        .audio_out_allowed      (allowed),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_out),
        .right_channel_audio_out(right_out),
        .env_level              (env_level),
        .env_state              (env_state),
        .overrun_count          (overrun_count)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int lvl_up(input int l);
        return (l + ATTACK_STEP > MAXL) ? MAXL : l + ATTACK_STEP;
    endfunction

    function automatic int lvl_down(input int l);
        return (l - RELEASE_STEP < 0) ? 0 : l - RELEASE_STEP;
    endfunction

    task automatic env_step(input logic g);
        case (m_state)
            S_IDLE: begin
                if (g) begin m_state = S_ATTACK; m_level = lvl_up(0); end
                else m_level = 0;
            end
            S_ATTACK: begin
                if (!g) begin m_state = S_RELEASE; m_level = lvl_down(m_level); end
                else begin
                    m_level = lvl_up(m_level);
                    if (m_level == MAXL) m_state = S_SUSTAIN;
                end
            end
            S_SUSTAIN: begin
                if (!g) begin m_state = S_RELEASE; m_level = lvl_down(m_level); end
            end
            default: begin
                if (g) begin m_state = S_ATTACK; m_level = lvl_up(m_level); end
                else begin
                    m_level = lvl_down(m_level);
                    if (m_level == 0) m_state = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_cnt     = 0;
        m_state   = S_IDLE;
        m_level   = 0;
        m_sample  = '0;
        m_overrun = 0;
    endtask

    // One clock: scoreboard the current outputs, advance the model, step the DUT.
    task automatic cycle();
        logic exp_write;
        int   s;
        #1;
        exp_write = (exp_q.size() != 0) && allowed;
        checks++;
        if (write_audio_out !== exp_write) begin
            failures++;
            $display("FAIL write_strobe t=%0t got=%0b exp=%0b", $time, write_audio_out, exp_write);
        end
        if (exp_write) begin
            checks++;
            if (left_out !== exp_q[0] || right_out !== exp_q[0]) begin
                failures++;
                $display("FAIL written_sample t=%0t got_l=%h got_r=%h exp=%h", $time, left_out, right_out, exp_q[0]);
            end
        end
        checks++;
        if (env_level !== ENV_W'(m_level) || env_state !== 2'(m_state)) begin
            failures++;
            $display("FAIL envelope t=%0t got_lvl=%0d got_st=%0d exp_lvl=%0d exp_st=%0d",
                     $time, env_level, env_state, m_level, m_state);
        end
        checks++;
        if (overrun_count !== 8'(m_overrun) || left_out !== m_sample) begin
            failures++;
            $display("FAIL overrun_or_sample t=%0t got_ov=%0d got_s=%h exp_ov=%0d exp_s=%h",
                     $time, overrun_count, left_out, m_overrun, m_sample);
        end

        if (exp_write) begin
            void'(exp_q.pop_front());
            n_writes++;
        end
        if (m_cnt == SAMPLE_DIV - 1) begin
            env_step(gate);
            s = (m_level << AMP_SHIFT);
            m_sample = tone ? 32'(s) : 32'(-s);
            if (exp_q.size() != 0) begin
                exp_q[0] = m_sample;
                if (m_overrun < 255) m_overrun++;
            end else begin
                exp_q.push_back(m_sample);
            end
            n_ticks++;
        end
        m_cnt = (m_cnt + 1) % SAMPLE_DIV;
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_ticks(input int n);
        int target = n_ticks + n;
        int budget = (n + 1) * SAMPLE_DIV;
        while (n_ticks < target && budget > 0) begin
            cycle();
            budget--;
        end
        checks++;
        if (n_ticks != target) begin
            failures++;
            $display("FAIL tick_budget got=%0d exp=%0d", n_ticks, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        gate = 1'b0; tone = 1'b0; allowed = 1'b1; reset_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (write_audio_out !== 1'b0 || left_out !== 32'd0 || right_out !== 32'd0 ||
            env_state !== 2'd0 || env_level !== '0 || overrun_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_values wr=%0b l=%h r=%h st=%0d lvl=%0d ov=%0d exp=all_zero",
                     write_audio_out, left_out, right_out, env_state, env_level, overrun_count);
        end
        reset_n = 1'b1;
        n_writes = 0;
        run_cycles(16);
        checks++;
        if (n_writes != 3) begin
            failures++;
            $display("FAIL idle_write_rate got=%0d exp=3", n_writes);
        end
    endtask

    task automatic test_attack();
        int lv[4] = '{4, 8, 12, 15};
        int st[4] = '{1, 1, 1, 2};
        gate = 1'b1; tone = 1'b1; allowed = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_ticks(1);
            checks++;
            if (env_level !== ENV_W'(lv[i]) || env_state !== 2'(st[i]) || left_out !== 32'(lv[i])) begin
                failures++;
                $display("FAIL attack_step%0d lvl=%0d st=%0d s=%h exp_lvl=%0d exp_st=%0d",
                         i, env_level, env_state, left_out, lv[i], st[i]);
            end
        end
        tone = 1'b0;
        run_ticks(1);
        checks++;
        if (left_out !== 32'hFFFF_FFF1 || right_out !== 32'hFFFF_FFF1 || env_state !== 2'd2) begin
            failures++;
            $display("FAIL negative_peak l=%h r=%h st=%0d exp=fffffff1 st=2", left_out, right_out, env_state);
        end
    endtask

    task automatic test_release_retrigger();
        int lv_a[4] = '{13, 11, 9, 7};
        int lv_b[6] = '{9, 7, 5, 3, 1, 0};
        int st_b[6] = '{3, 3, 3, 3, 3, 0};
        gate = 1'b0; tone = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_ticks(1);
            checks++;
            if (env_level !== ENV_W'(lv_a[i]) || env_state !== 2'd3) begin
                failures++;
                $display("FAIL release_step%0d lvl=%0d st=%0d exp_lvl=%0d exp_st=3", i, env_level, env_state, lv_a[i]);
            end
        end
        gate = 1'b1;
        run_ticks(1);
        checks++;
        if (env_level !== ENV_W'(11) || env_state !== 2'd1) begin
            failures++;
            $display("FAIL retrigger lvl=%0d st=%0d exp_lvl=11 exp_st=1", env_level, env_state);
        end
        gate = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_ticks(1);
            checks++;
            if (env_level !== ENV_W'(lv_b[i]) || env_state !== 2'(st_b[i])) begin
                failures++;
                $display("FAIL decay_step%0d lvl=%0d st=%0d exp_lvl=%0d exp_st=%0d",
                         i, env_level, env_state, lv_b[i], st_b[i]);
            end
        end
        run_ticks(2);
        checks++;
        if (env_level !== '0 || env_state !== 2'd0 || left_out !== 32'd0) begin
            failures++;
            $display("FAIL no_underflow lvl=%0d st=%0d s=%h exp=0/0/0", env_level, env_state, left_out);
        end
    endtask

    task automatic test_backpressure();
        int ov0;
        int w0;
        gate = 1'b1; tone = 1'b1; allowed = 1'b1;
        run_ticks(1);
        cycle();
        allowed = 1'b0;
        ov0 = overrun_count;
        w0 = n_writes;
        run_ticks(3);
        checks++;
        if (n_writes != w0 || overrun_count !== 8'(ov0 + 2)) begin
            failures++;
            $display("FAIL backpressure writes=%0d ov=%0d exp_writes=%0d exp_ov=%0d",
                     n_writes - w0, overrun_count, 0, ov0 + 2);
        end
        allowed = 1'b1;
        w0 = n_writes;
        run_cycles(SAMPLE_DIV);
        checks++;
        if (n_writes != w0 + 1) begin
            failures++;
            $display("FAIL single_write_after_enable got=%0d exp=1", n_writes - w0);
        end
    endtask

    task automatic test_overrun_saturation();
        int ov0;
        int w0;
        allowed = 1'b0;
        while (m_cnt != SAMPLE_DIV - 1) cycle();
        allowed = 1'b1;
        ov0 = overrun_count;
        w0 = n_writes;
        cycle();
        checks++;
        if (overrun_count !== 8'(ov0) || n_writes != w0 + 1 || write_audio_out !== 1'b1) begin
            failures++;
            $display("FAIL tick_with_write ov=%0d wr=%0b writes=%0d exp_ov=%0d exp_wr=1 exp_writes=1",
                     overrun_count, write_audio_out, n_writes - w0, ov0);
        end
        allowed = 1'b0;
        run_ticks(262);
        checks++;
        if (overrun_count !== 8'd255) begin
            failures++;
            $display("FAIL overrun_saturate got=%0d exp=255", overrun_count);
        end
        allowed = 1'b1;
        run_cycles(2 * SAMPLE_DIV);
    endtask

    task automatic test_reset_mid_op();
        int n;
        reset_n = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        gate = 1'b1; tone = 1'b1; allowed = 1'b0;
        run_ticks(3);
        checks++;
        if (env_level !== ENV_W'(12) || left_out !== 32'd12 || write_audio_out !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset lvl=%0d s=%h wr=%0b exp=12/0000000c/0", env_level, left_out, write_audio_out);
        end
        allowed = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if (write_audio_out !== 1'b0 || left_out !== 32'd0 || right_out !== 32'd0 ||
            env_level !== '0 || env_state !== 2'd0 || overrun_count !== 8'd0) begin
            failures++;
            $display("FAIL async_clear wr=%0b l=%h r=%h lvl=%0d st=%0d ov=%0d exp=all_zero",
                     write_audio_out, left_out, right_out, env_level, env_state, overrun_count);
        end
        model_clear();
        @(posedge clk);
        #1;
        gate = 1'b0;
        reset_n = 1'b1;
        n = 0;
        while (n < 10) begin
            cycle();
            n++;
            if (write_audio_out === 1'b1) break;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL first_strobe_after_reset got=%0d exp=4", n);
        end
    endtask

    task automatic test_random();
        int w0 = n_writes;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) gate = ~gate;
            tone = 1'($urandom_range(0, 1));
            allowed = ($urandom_range(0, 3) != 0);
            cycle();
        end
        checks++;
        if (n_writes == w0) begin
            failures++;
            $display("FAIL random_activity writes=0 exp=nonzero");
        end
    endtask

    initial begin
        n_writes = 0;
        n_ticks  = 0;
        test_reset();
        test_attack();
        test_release_retrigger();
        test_backpressure();
        test_overrun_saturation();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
